sram_pixel_streamer: RTL and testbench

Read-side streamer that sits directly downstream of the 64-bit line SRAM in the 1024x1024 convolution datapath. On a start command it issues sequential SRAM reads from a base word address. It absorbs the SRAM's one-cycle registered read latency in a 2-entry word buffer. It unpacks each 64-bit word into eight 8-bit pixels on a valid/ready stream that feeds the 4x4 window builder.

---
 rtl/conv_pkg.sv | 15 +
 rtl/word_fifo2.sv | 64 ++++++
 rtl/sram_pixel_streamer.sv | 147 ++++++++++++++
 tb/tb_sram_pixel_streamer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution read path.
package conv_pkg;

  localparam int PIX_WIDTH    = 8;
  localparam int PIX_PER_WORD = 64 / PIX_WIDTH;

  typedef logic [PIX_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } streamer_state_e;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO holding SRAM words between read return and unpacking.
module word_fifo2 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_pixel_streamer.sv
// Streams sequential SRAM words as LSB-first pixels on a valid/ready port.
// Stream handshake: a pixel transfers when pix_valid && pix_ready; while pix_valid && !pix_ready, pix_data and pix_valid hold.
module sram_pixel_streamer
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int PIX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_read_address,
  output logic                  sram_read_enable,
  input  logic [DATA_WIDTH-1:0] sram_read_data,
  input  logic                  sram_read_valid,
  output logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last,
  output streamer_state_e       dbg_state
);

  localparam int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH;
  localparam int IDX_W        = $clog2(PIX_PER_WORD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PIX_PER_WORD - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  streamer_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   popped_q, popped_d;
  logic                  inflight_q, inflight_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] head_word;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [1:0]            fifo_count, credit;
  logic                  pix_hs, final_word;

  // Reads returning with nothing outstanding are stale and dropped.
  assign fifo_push = sram_read_valid && inflight_q;
  assign fifo_pop  = pix_hs && (idx_q == LAST_IDX);

  word_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (sram_read_data),
    .pop       (fifo_pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign credit            = fifo_count + {1'b0, inflight_q};
  assign sram_read_enable  = (state_q == RUN) && (issued_q != count_q) &&
                             !inflight_q && (credit < 2'd2);
  assign sram_read_address = base_q + issued_q[ADDR_WIDTH-1:0];

  assign pix_valid  = !fifo_empty;
  assign pix_hs     = pix_valid && pix_ready;
  assign pix_data   = pix_valid ? head_word[idx_q*PIX_WIDTH +: PIX_WIDTH] : '0;
  assign final_word = (popped_q + CNT_ONE) == count_q;
  assign pix_last   = pix_valid && final_word && (idx_q == LAST_IDX);

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    inflight_d = inflight_q;
    idx_d      = idx_q;
    done_d     = 1'b0;

    if (sram_read_enable)  inflight_d = 1'b1;
    else if (fifo_push)    inflight_d = 1'b0;
    if (pix_hs)   idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
    if (fifo_pop) popped_d = popped_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d  = RUN;
            base_d   = base_address;
            count_d  = word_count;
            issued_d = '0;
            popped_d = '0;
            idx_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (sram_read_enable) begin
          issued_d = issued_q + CNT_ONE;
          if (issued_q + CNT_ONE == count_q) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pix_hs && pix_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_sram_pixel_streamer.sv
// Directed bench for sram_pixel_streamer with a one-cycle-latency SRAM model.
module tb_sram_pixel_streamer;
  import conv_pkg::*;

  localparam int AW = 12;
  localparam int DW = 64;
  localparam int PW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [AW-1:0]   base_address = '0;
  logic [AW:0]     word_count = '0;
  logic            busy, done;
  logic [AW-1:0]   sram_read_address;
  logic            sram_read_enable;
  logic [DW-1:0]   sram_read_data = '0;
  logic            sram_read_valid = 1'b0;
  logic [PW-1:0]   pix_data;
  logic            pix_valid, pix_last;
  logic            pix_ready = 1'b1;
  streamer_state_e dbg_state;

  sram_pixel_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIX_WIDTH(PW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_address      (base_address),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .sram_read_address (sram_read_address),
    .sram_read_enable  (sram_read_enable),
    .sram_read_data    (sram_read_data),
    .sram_read_valid   (sram_read_valid),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_last          (pix_last),
    .dbg_state         (dbg_state)
  );

  // SRAM model; inject_valid produces a stray return with no request behind it
  logic [DW-1:0] sram [4096];
  logic          inject_valid = 1'b0;
  always @(posedge clk) begin
    sram_read_valid <= sram_read_enable || inject_valid;
    sram_read_data  <= inject_valid ? 64'hBAD0_BAD0_BAD0_BAD0 : sram[sram_read_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  logic [PW-1:0] got_q[$];
  int            got_cyc_q[$];
  int            last_pos_q[$];
  logic [AW-1:0] addr_q[$];
  int            addr_cyc_q[$];
  int done_cnt, done_cyc, busy_cnt, first_busy, stall_err, dbl_rd_err, busy_done_err;
  logic prev_stall = 1'b0, prev_ren = 1'b0;
  logic [PW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_ren   = 1'b0;
    end else begin
      if (prev_stall && (!pix_valid || pix_data != prev_data)) stall_err++;
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      if (sram_read_enable) begin
        if (prev_ren) dbl_rd_err++;
        addr_q.push_back(sram_read_address);
        addr_cyc_q.push_back(cyc);
      end
      prev_ren = sram_read_enable;
      if (pix_valid && pix_ready) begin
        if (pix_last) last_pos_q.push_back(got_q.size());
        got_q.push_back(pix_data);
        got_cyc_q.push_back(cyc);
      end
      if (busy) begin
        if (busy_cnt == 0) first_busy = cyc;
        busy_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) busy_done_err++;
      end
    end
  end

  // scoreboard
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete(); got_cyc_q.delete(); last_pos_q.delete();
    addr_q.delete(); addr_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; first_busy = -1;
    stall_err = 0; dbl_rd_err = 0; busy_done_err = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  64'(busy), 0);
    check({tag, "_done"},  64'(done), 0);
    check({tag, "_ren"},   64'(sram_read_enable), 0);
    check({tag, "_addr"},  64'(sram_read_address), 0);
    check({tag, "_valid"}, 64'(pix_valid), 0);
    check({tag, "_last"},  64'(pix_last), 0);
    check({tag, "_data"},  64'(pix_data), 0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // restart_at > 0 issues a second start that many cycles into the job
  task automatic run_job(input logic [AW-1:0] b, input logic [AW:0] n, input bit rnd,
                         input int restart_at, output int c0);
    int k;
    clear_mon();
    base_address = b;
    word_count   = n;
    start        = 1'b1;
    pix_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    c0           = cyc;
    step();
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 1000) begin
      k++;
      if (k == restart_at) begin
        start = 1'b1; base_address = 12'h080; word_count = 13'd5;
      end else begin
        start = 1'b0;
      end
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic verify(input string name, input logic [AW-1:0] b, input int n,
                        input int c0, input bit timing);
    logic [PW-1:0] exp_q[$];
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    for (int wi = 0; wi < n; wi++) begin
      a = b + AW'(wi);
      w = sram[a];
      for (int k = 0; k < DW / PW; k++) exp_q.push_back(w[k*PW +: PW]);
    end
    check({name, "_npix"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_pix%0d", name, i), (i < got_q.size()) ? 64'(got_q[i]) : 64'hx, 64'(exp_q[i]));
    check({name, "_nlast"}, 64'(last_pos_q.size()), 1);
    check({name, "_lastpos"}, (last_pos_q.size() > 0) ? 64'(last_pos_q[0]) : 64'hx, 64'(8*n - 1));
    check({name, "_ndone"}, 64'(done_cnt), 1);
    check({name, "_busy_at_done"}, 64'(busy_done_err), 0);
    check({name, "_stall_stable"}, 64'(stall_err), 0);
    check({name, "_one_inflight"}, 64'(dbl_rd_err), 0);
    check({name, "_nreads"}, 64'(addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < addr_q.size(); i++)
      check($sformatf("%s_addr%0d", name, i), 64'(addr_q[i]), 64'(AW'(b + AW'(i))));
    if (timing) begin
      check({name, "_busy_cyc"}, 64'(first_busy - c0), 1);
      check({name, "_ren_cyc"}, (addr_cyc_q.size() > 0) ? 64'(addr_cyc_q[0] - c0) : 64'hx, 1);
      check({name, "_first_pix_cyc"}, (got_cyc_q.size() > 0) ? 64'(got_cyc_q[0] - c0) : 64'hx, 3);
      check({name, "_last_pix_cyc"}, (got_cyc_q.size() > 0) ? 64'(got_cyc_q[got_cyc_q.size()-1] - c0) : 64'hx,
            64'(8*n + 2));
      check({name, "_done_cyc"}, 64'(done_cyc - c0), 64'(8*n + 3));
    end
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 4096; i++) sram[i] = {$urandom, $urandom};
    sram[12'h010] = 64'h0706_0504_0302_0100;
    sram[12'h011] = 64'h0F0E_0D0C_0B0A_0908;
    sram[12'hFFF] = 64'h1716_1514_1312_1110;
    sram[12'h000] = 64'h1F1E_1D1C_1B1A_1918;
    clear_mon();

    // reset state
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_idle_outputs("in_reset");
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    check_idle_outputs("after_reset");
    step();

    // basic job, hand-computed pixels 0x00..0x0F
    run_job(12'h010, 13'd2, 1'b0, -1, c0);
    verify("basic", 12'h010, 2, c0, 1'b1);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check($sformatf("basic_hand%0d", i), 64'(got_q[i]), 64'(i));

    // backpressure
    run_job(12'h010, 13'd2, 1'b1, -1, c0);
    verify("bp", 12'h010, 2, c0, 1'b0);

    // address wrap
    run_job(12'hFFF, 13'd2, 1'b0, -1, c0);
    verify("wrap", 12'hFFF, 2, c0, 1'b1);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check($sformatf("wrap_hand%0d", i), 64'(got_q[i]), 64'(8'h10 + i));

    // zero count
    clear_mon();
    base_address = 12'h123;
    word_count   = '0;
    start        = 1'b1;
    c0           = cyc;
    step();
    start = 1'b0;
    repeat (5) step();
    check("zero_ndone", 64'(done_cnt), 1);
    check("zero_done_cyc", 64'(done_cyc - c0), 1);
    check("zero_nreads", 64'(addr_q.size()), 0);
    check("zero_busy", 64'(busy_cnt), 0);
    check("zero_npix", 64'(got_q.size()), 0);

    // reset in the middle of a 4-word job, during the third pixel
    clear_mon();
    base_address = 12'h020;
    word_count   = 13'd4;
    start        = 1'b1;
    pix_ready    = 1'b1;
    c0           = cyc;
    step();
    start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset        = 1'b0;
    inject_valid = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    step();
    inject_valid = 1'b0;
    step();
    @(negedge clk);
    check("straggler_valid", 64'(pix_valid), 0);
    check("straggler_busy", 64'(busy), 0);
    step();
    run_job(12'h030, 13'd1, 1'b0, -1, c0);
    verify("post_reset", 12'h030, 1, c0, 1'b1);

    // start while busy is ignored
    run_job(12'h040, 13'd3, 1'b0, 10, c0);
    verify("restart", 12'h040, 3, c0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
